// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: blank/off codes and the active-low glyph font.
// Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational 4-bit digit code to active-low 7-segment glyph; codes 10-15 render a dash.
// Zero latency, no flow control.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_DASH;
    case (code)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-segment driver with frame snapshot, one-cycle blank guard and leading-zero blanking.
// Tick to new digit visible: 2 cycles; no backpressure. Optional blinking under `SEG_BLINK_EN.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        lzb,
  input  logic [3:0]  blink_sel,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic          first_q, first_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic       tick;
  logic [3:0] code;
  logic [6:0] glyph;
  logic       lz_blank;
  logic       blink_off;

  assign tick = (cnt_q == CW'(REFRESH_DIV - 1));

`ifdef SEG_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          btick;

  assign btick = (bcnt_q == BW'(BLINK_DIV - 1));

  always_comb begin
    bcnt_d  = btick ? '0 : bcnt_q + 1'b1;
    phase_d = btick ? ~phase_q : phase_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_off = phase_q & blink_sel[idx_q];
`else
  logic unused_blink;
  assign unused_blink = ^blink_sel;
  assign blink_off    = 1'b0;
`endif

  always_comb begin
    code = snap_q[3:0];
    case (idx_q)
      2'd0: code = snap_q[3:0];
      2'd1: code = snap_q[7:4];
      2'd2: code = snap_q[11:8];
      2'd3: code = snap_q[15:12];
      default: code = snap_q[3:0];
    endcase
  end

  bcd_to_seg u_font (
    .code  (code),
    .glyph (glyph)
  );

  // A digit is a leading zero when it and every digit to its left in the snapshot are zero.
  always_comb begin
    lz_blank = 1'b0;
    case (idx_q)
      2'd1: lz_blank = (snap_q[15:4] == 12'h000);
      2'd2: lz_blank = (snap_q[15:8] == 8'h00);
      2'd3: lz_blank = (snap_q[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
    lz_blank = lz_blank & lzb;
  end

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = tick ? idx_q + 1'b1 : idx_q;
    first_d = 1'b0;
    // Capture on the wrap guard (and the post-reset guard) so a frame never tears.
    snap_d  = (first_q || (tick && idx_q == 2'd3)) ? digits : snap_q;

    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    if (!(first_q || tick)) begin
      an_d = ~(4'b0001 << idx_q);
      if (lz_blank || blink_off) begin
        seg_d = SEG_BLANK;
      end else begin
        seg_d = {~dp_mask[idx_q], glyph};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      snap_q  <= 16'h0000;
      first_q <= 1'b1;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      first_q <= first_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: every change of {an,seg} is queued and matched in order
// against expected display events pushed as stimulus is applied.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic        lzb = 1'b0;
  logic [3:0]  blink_sel = 4'h0;
  logic [7:0]  seg;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic [11:0] prev = 12'hxxx;

  seg_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .lzb       (lzb),
    .blink_sel (blink_sel),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ({an, seg} !== prev) begin
      obs_q.push_back({an, seg});
      prev = {an, seg};
    end
  end

  task automatic ev(input logic [3:0] a, input logic [7:0] s);
    exp_q.push_back({a, s});
  endtask

  task automatic guard();
    exp_q.push_back({4'hF, 8'hFF});
  endtask

  task automatic drain(input string tag);
    logic [11:0] o, e;
    int t;
    while (exp_q.size() > 0) begin
      t = 0;
      while (obs_q.size() == 0 && t < 200) begin
        @(negedge clk);
        #1;
        t++;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_err++;
        $error("FAIL %s: timeout, no output change; want an=%h seg=%h", tag, e[11:8], e[7:0]);
        exp_q.delete();
        return;
      end
      o = obs_q.pop_front();
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s: got an=%h seg=%h want an=%h seg=%h", tag, o[11:8], o[7:0], e[11:8], e[7:0]);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    ev(4'hF, 8'hFF);
    drain("reset");

    // Scan of 1234 after release
    digits = 16'h1234;
    rst_n  = 1'b1;
    ev(4'hE, 8'h99); guard(); ev(4'hD, 8'hB0);
    drain("scan1234");

    // Mid-frame change stays hidden until the next frame
    digits = 16'h5678;
    guard(); ev(4'hB, 8'hA4); guard(); ev(4'h7, 8'hF9); guard();
    ev(4'hE, 8'h80); guard(); ev(4'hD, 8'hF8); guard();
    ev(4'hB, 8'h82); guard(); ev(4'h7, 8'h92); guard();
    drain("snapshot");

    // Leading-zero blanking
    digits = 16'h0070;
    lzb    = 1'b1;
    ev(4'hE, 8'h80); guard(); ev(4'hD, 8'hF8); guard();
    ev(4'hB, 8'h82); guard(); ev(4'h7, 8'h92); guard();
    ev(4'hE, 8'hC0);
    drain("lzb_0070a");
    digits = 16'h0000;
    guard(); ev(4'hD, 8'hF8); guard(); ev(4'hB, 8'hFF); guard(); ev(4'h7, 8'hFF); guard();
    ev(4'hE, 8'hC0); guard(); ev(4'hD, 8'hFF); guard();
    ev(4'hB, 8'hFF); guard(); ev(4'h7, 8'hFF); guard();
    drain("lzb_0000");

    // Live decimal point and dash glyph
    lzb     = 1'b0;
    dp_mask = 4'b0100;
    digits  = 16'h1234;
    ev(4'hE, 8'hC0); guard(); ev(4'hD, 8'hC0); guard();
    ev(4'hB, 8'h40); guard(); ev(4'h7, 8'hC0); guard();
    ev(4'hE, 8'h99);
    drain("dp_zero");
    digits = 16'h12B4;
    guard(); ev(4'hD, 8'hB0); guard(); ev(4'hB, 8'h24); guard(); ev(4'h7, 8'hF9); guard();
    ev(4'hE, 8'h99); guard(); ev(4'hD, 8'hBF); guard();
    ev(4'hB, 8'h24); guard(); ev(4'h7, 8'hF9); guard();
    drain("dp_dash");

    // Blink select on d0
    blink_sel = 4'b0001;
`ifdef SEG_BLINK_EN
    begin
      logic saw_b, saw_g, bad;
      saw_b = 1'b0; saw_g = 1'b0; bad = 1'b0;
      for (int i = 0; i < 96; i++) begin
        @(negedge clk);
        #1;
        if (an == 4'hE && seg == 8'hFF) saw_b = 1'b1;
        if (an == 4'hE && seg == 8'h99) saw_g = 1'b1;
        if (an == 4'hD && seg != 8'hBF) bad = 1'b1;
      end
      n_cmp++;
      assert ({saw_b, saw_g} === 2'b11) else begin
        n_err++;
        $error("FAIL blink_d0: got blank=%b glyph=%b want 1 1", saw_b, saw_g);
      end
      n_cmp++;
      assert (bad === 1'b0) else begin
        n_err++;
        $error("FAIL blink_other: got disturbed=%b want 0", bad);
      end
    end
`else
    for (int f = 0; f < 2; f++) begin
      ev(4'hE, 8'h99); guard(); ev(4'hD, 8'hBF); guard();
      ev(4'hB, 8'h24); guard(); ev(4'h7, 8'hF9); guard();
    end
    drain("blink_off");
`endif
    blink_sel = 4'b0000;

    // Reset mid-slot while idx=2
    begin
      int t;
      t = 0;
      while (an !== 4'hB && t < 100) begin
        @(negedge clk);
        #1;
        t++;
      end
      n_cmp++;
      assert (an === 4'hB) else begin
        n_err++;
        $error("FAIL find_idx2: got an=%h want an=b", an);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    assert (an === 4'hF) else begin
      n_err++;
      $error("FAIL midrst_an: got %h want f", an);
    end
    n_cmp++;
    assert (seg === 8'hFF) else begin
      n_err++;
      $error("FAIL midrst_seg: got %h want ff", seg);
    end
    @(negedge clk);
    #1;
    obs_q.delete();
    rst_n = 1'b1;
    ev(4'hE, 8'h99); guard(); ev(4'hD, 8'hBF);
    drain("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
